// File: rtl/shim_ads816x_adc_rx_if.sv
// Data-FIFO write port of the ADS816x MISO receiver.
// master = receiver (produces words), slave = FIFO (reports full).
interface shim_ads816x_adc_rx_if;
    logic        data_word_wr_en;
    logic [31:0] data_word;
    logic        data_buf_full;

    modport master (output data_word_wr_en, output data_word, input  data_buf_full);
    modport slave  (input  data_word_wr_en, input  data_word, output data_buf_full);
endinterface

// File: rtl/shim_ads816x_adc_rx.sv
// ADS816x MISO receive path: oversamples n_cs/miso_sck/miso, deserialises 16-bit frames,
// drops the stale first word of a read and writes sample pairs to the data FIFO.
// Write strobe lands SYNC_STAGES+2 clk after n_cs rises; a full FIFO loses the word (sticky flag).
module shim_ads816x_adc_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int WORDS_PER_READ = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_start,
    input  logic                        n_cs,
    input  logic                        miso_sck,
    input  logic                        miso,
    shim_ads816x_adc_rx_if.master       fifo,
    output logic                        rd_done,
    output logic                        frame_err,
    output logic                        data_buf_overflow
);

    localparam int IDX_W = $clog2(WORDS_PER_READ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_READ - 1);

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, miso_sync;
    logic                   cs_s, sck_s, miso_s;
    logic                   cs_prev, sck_prev;
    logic                   cs_fall_p, cs_rise_p, sck_bit_p, miso_bit;
    logic                   armed;
    logic [IDX_W-1:0]       word_idx;
    logic [4:0]             bit_cnt;
    logic [15:0]            shift;
    logic [15:0]            held;

    // n_cs idles high so a reset taken mid-frame resynchronises on a fresh fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            miso_sync <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   n_cs};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  miso_sck};
            miso_sync <= {miso_sync[SYNC_STAGES-2:0], miso};
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign miso_s = miso_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_prev                <= 1'b1;
            sck_prev               <= 1'b0;
            cs_fall_p              <= 1'b0;
            cs_rise_p              <= 1'b0;
            sck_bit_p              <= 1'b0;
            miso_bit               <= 1'b0;
            armed                  <= 1'b0;
            word_idx               <= '0;
            bit_cnt                <= '0;
            shift                  <= '0;
            held                   <= '0;
            fifo.data_word_wr_en   <= 1'b0;
            fifo.data_word         <= '0;
            rd_done                <= 1'b0;
            frame_err              <= 1'b0;
            data_buf_overflow      <= 1'b0;
        end else begin
            // Edge pulses are registered together with the data bit so all stay aligned.
            cs_prev   <= cs_s;
            sck_prev  <= sck_s;
            cs_fall_p <= cs_prev & ~cs_s;
            cs_rise_p <= ~cs_prev & cs_s;
            sck_bit_p <= sck_s & ~sck_prev & ~cs_s;
            miso_bit  <= miso_s;

            fifo.data_word_wr_en <= 1'b0;
            rd_done              <= 1'b0;

            if (cs_fall_p) begin
                bit_cnt <= '0;
            end else if (sck_bit_p) begin
                shift <= {shift[14:0], miso_bit};
                if (bit_cnt != 5'd31)
                    bit_cnt <= bit_cnt + 5'd1;
            end

            // rd_start takes priority over a coincident frame end, which is then dropped.
            if (rd_start) begin
                armed    <= 1'b1;
                word_idx <= '0;
                held     <= '0;
            end else if (cs_rise_p && armed) begin
                if (bit_cnt != 5'd16) begin
                    frame_err <= 1'b1;
                end else begin
                    if (word_idx == '0) begin
                        held <= held;
                    end else if (word_idx[0]) begin
                        held <= shift;
                    end else if (fifo.data_buf_full) begin
                        data_buf_overflow <= 1'b1;
                    end else begin
                        fifo.data_word_wr_en <= 1'b1;
                        fifo.data_word       <= {shift, held};
                    end

                    if (word_idx == LAST_IDX) begin
                        rd_done  <= 1'b1;
                        armed    <= 1'b0;
                        word_idx <= '0;
                    end else begin
                        word_idx <= word_idx + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule
